// File: rtl/bc_datapath.sv
// Basic-computer common-bus datapath: registers, E flag, ALU and word memory.
// Bus source, register enables and ALU op all come from the controller.
module bc_datapath #(
    parameter int WIDTH      = 16,
    parameter int AWIDTH     = 12,
    parameter int CTRL_LNGTH = 21,
    parameter     MEM_INIT   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            bus_sel,
    input  logic [CTRL_LNGTH-2:0] ctrl_en,
    input  logic [2:0]            alu_op,
    output logic [WIDTH-1:0]      ir,
    output logic                  co,
    output logic                  z,
    output logic                  n,
    output logic                  ovf,
    output logic                  e_out,
    output logic [WIDTH-1:0]      bus,
    output logic [AWIDTH-1:0]     ar,
    output logic [AWIDTH-1:0]     pc,
    output logic [WIDTH-1:0]      ac
);

    localparam int PADW = WIDTH - AWIDTH;
    localparam logic [AWIDTH-1:0] A_ONE = 1;
    localparam logic [WIDTH-1:0]  W_ONE = 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_CMA = 3'b011;
    localparam logic [2:0] OP_CIL = 3'b100;
    localparam logic [2:0] OP_CIR = 3'b101;

    logic [AWIDTH-1:0] ar_q, ar_d, pc_q, pc_d;
    logic [WIDTH-1:0]  dr_q, dr_d, ac_q, ac_d;
    logic [WIDTH-1:0]  ir_q, ir_d, tr_q, tr_d;
    logic              e_q, e_d, co_q, co_d, ovf_q, ovf_d;

    logic [WIDTH-1:0] mem [2**AWIDTH];
    logic [WIDTH-1:0] mem_rd;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_ac;
    logic             alu_e, alu_e_wr, alu_add;

    // Entry 17 is reserved and intentionally ignored.
    logic unused_en;
    assign unused_en = ctrl_en[17];

    assign mem_rd = mem[ar_q];

    always_comb begin
        bus = '0;
        case (bus_sel)
            3'b001:  bus = {{PADW{1'b0}}, pc_q};
            3'b010:  bus = dr_q;
            3'b011:  bus = ac_q;
            3'b100:  bus = ir_q;
            3'b101:  bus = tr_q;
            3'b110:  bus = mem_rd;
            3'b111:  bus = {{PADW{1'b0}}, ar_q};
            default: bus = '0;
        endcase
    end

    assign sum = {1'b0, ac_q} + {1'b0, dr_q};

    always_comb begin
        alu_ac   = ac_q;
        alu_e    = e_q;
        alu_e_wr = 1'b0;
        alu_add  = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_ac   = sum[WIDTH-1:0];
                alu_e    = sum[WIDTH];
                alu_e_wr = 1'b1;
                alu_add  = 1'b1;
            end
            OP_AND: alu_ac = ac_q & dr_q;
            OP_LDA: alu_ac = dr_q;
            OP_CMA: alu_ac = ~ac_q;
            OP_CIL: begin
                alu_ac   = {ac_q[WIDTH-2:0], e_q};
                alu_e    = ac_q[WIDTH-1];
                alu_e_wr = 1'b1;
            end
            OP_CIR: begin
                alu_ac   = {e_q, ac_q[WIDTH-1:1]};
                alu_e    = ac_q[0];
                alu_e_wr = 1'b1;
            end
            default: alu_ac = ac_q;
        endcase
    end

    // Each register resolves clr > load > inc independently.
    always_comb begin
        ar_d = ar_q;
        if (ctrl_en[2])      ar_d = '0;
        else if (ctrl_en[0]) ar_d = bus[AWIDTH-1:0];
        else if (ctrl_en[1]) ar_d = ar_q + A_ONE;

        pc_d = pc_q;
        if (ctrl_en[5])      pc_d = '0;
        else if (ctrl_en[3]) pc_d = bus[AWIDTH-1:0];
        else if (ctrl_en[4]) pc_d = pc_q + A_ONE;

        dr_d = dr_q;
        if (ctrl_en[8])      dr_d = '0;
        else if (ctrl_en[6]) dr_d = bus;
        else if (ctrl_en[7]) dr_d = dr_q + W_ONE;

        ac_d = ac_q;
        if (ctrl_en[11])     ac_d = '0;
        else if (ctrl_en[9]) ac_d = alu_ac;
        else if (ctrl_en[10]) ac_d = ac_q + W_ONE;

        ir_d = ctrl_en[12] ? bus : ir_q;

        tr_d = tr_q;
        if (ctrl_en[15])      tr_d = '0;
        else if (ctrl_en[13]) tr_d = bus;
        else if (ctrl_en[14]) tr_d = tr_q + W_ONE;

        e_d = e_q;
        if (ctrl_en[19])                  e_d = 1'b0;
        else if (ctrl_en[18])             e_d = ~e_q;
        else if (ctrl_en[9] && alu_e_wr)  e_d = alu_e;

        co_d  = co_q;
        ovf_d = ovf_q;
        if (ctrl_en[9] && alu_add) begin
            co_d  = sum[WIDTH];
            ovf_d = (ac_q[WIDTH-1] == dr_q[WIDTH-1]) &&
                    (sum[WIDTH-1] != ac_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_q  <= '0;
            pc_q  <= '0;
            dr_q  <= '0;
            ac_q  <= '0;
            ir_q  <= '0;
            tr_q  <= '0;
            e_q   <= 1'b0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            ar_q  <= ar_d;
            pc_q  <= pc_d;
            dr_q  <= dr_d;
            ac_q  <= ac_d;
            ir_q  <= ir_d;
            tr_q  <= tr_d;
            e_q   <= e_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
        end
    end

    // Memory is not reset; the write address is the pre-edge AR.
    always_ff @(posedge clk) begin
        if (ctrl_en[16]) mem[ar_q] <= bus;
    end

    assign ir    = ir_q;
    assign co    = co_q;
    assign ovf   = ovf_q;
    assign e_out = e_q;
    assign z     = (ac_q == '0);
    assign n     = ac_q[WIDTH-1];
    assign ar    = ar_q;
    assign pc    = pc_q;
    assign ac    = ac_q;

endmodule

// File: tb/tb_bc_datapath.sv
// Scoreboard bench for bc_datapath: an arithmetic reference model predicts
// every cycle's visible state, a monitor compares after each rising edge.
module tb_bc_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  bus_sel;
    logic [19:0] ctrl_en;
    logic [2:0]  alu_op;
    logic [15:0] ir, bus, ac;
    logic        co, z, n, ovf, e_out;
    logic [11:0] ar, pc;

    bc_datapath dut (
        .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .ctrl_en(ctrl_en),
        .alu_op(alu_op), .ir(ir), .co(co), .z(z), .n(n), .ovf(ovf),
        .e_out(e_out), .bus(bus), .ar(ar), .pc(pc), .ac(ac)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ar, pc, ac, ir, bus, e, co, ovf;
    } exp_t;

    exp_t q[$];
    int passed = 0;
    int total  = 0;

    // Reference model state as plain integers.
    int m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_e, m_co, m_ovf;
    int m_mem [4096];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int mbus(input int s);
        case (s)
            1: return m_pc;
            2: return m_dr;
            3: return m_ac;
            4: return m_ir;
            5: return m_tr;
            6: return m_mem[m_ar];
            7: return m_ar;
            default: return 0;
        endcase
    endfunction

    function automatic logic [19:0] b(input int k);
        logic [19:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic int upd(input int cur, input bit clr, input bit ld,
                               input bit inc, input int ldv, input int m);
        if (clr) return 0;
        if (ld)  return ldv % m;
        if (inc) return (cur + 1) % m;
        return cur;
    endfunction

    task automatic model_reset();
        m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0;
        m_tr = 0; m_e = 0; m_co = 0; m_ovf = 0;
    endtask

    task automatic cycle(input int s, input logic [19:0] en, input int op);
        int bv, nac, ne, sum, sa, sd, ss, alu_ac, alu_e;
        bit ewr;
        exp_t x;
        @(negedge clk);
        bus_sel = 3'(s);
        ctrl_en = en;
        alu_op  = 3'(op);
        bv = mbus(s);
        alu_ac = m_ac;
        alu_e  = m_e;
        ewr    = 0;
        case (op)
            0: begin
                sum = m_ac + m_dr;
                alu_ac = sum % 65536;
                alu_e  = sum / 65536;
                ewr = 1;
            end
            1: alu_ac = m_ac & m_dr;
            2: alu_ac = m_dr;
            3: alu_ac = 65535 - m_ac;
            4: begin
                alu_ac = (m_ac * 2 + m_e) % 65536;
                alu_e  = m_ac / 32768;
                ewr = 1;
            end
            5: begin
                alu_ac = m_ac / 2 + m_e * 32768;
                alu_e  = m_ac % 2;
                ewr = 1;
            end
            default: ;
        endcase
        if (en[9] && op == 0) begin
            sa = (m_ac >= 32768) ? m_ac - 65536 : m_ac;
            sd = (m_dr >= 32768) ? m_dr - 65536 : m_dr;
            ss = sa + sd;
            m_co  = (m_ac + m_dr) / 65536;
            m_ovf = (ss > 32767 || ss < -32768) ? 1 : 0;
        end
        if (en[19])          ne = 0;
        else if (en[18])     ne = 1 - m_e;
        else if (en[9] && ewr) ne = alu_e;
        else                 ne = m_e;
        if (en[11])      nac = 0;
        else if (en[9])  nac = alu_ac;
        else if (en[10]) nac = (m_ac + 1) % 65536;
        else             nac = m_ac;
        if (en[16]) m_mem[m_ar] = bv;
        m_ar = upd(m_ar, en[2], en[0], en[1], bv, 4096);
        m_pc = upd(m_pc, en[5], en[3], en[4], bv, 4096);
        m_dr = upd(m_dr, en[8], en[6], en[7], bv, 65536);
        m_tr = upd(m_tr, en[15], en[13], en[14], bv, 65536);
        if (en[12]) m_ir = bv;
        m_ac = nac;
        m_e  = ne;
        x.ar = m_ar; x.pc = m_pc; x.ac = m_ac; x.ir = m_ir;
        x.e = m_e; x.co = m_co; x.ovf = m_ovf;
        x.bus = mbus(s);
        q.push_back(x);
        @(posedge clk);
    endtask

    // Builds a constant in AC by rotating E in one bit at a time.
    task automatic set_ac(input logic [15:0] v);
        cycle(0, b(11) | b(19), 7);
        for (int i = 15; i >= 0; i--) begin
            cycle(0, b(19), 7);
            if (v[i]) cycle(0, b(18), 7);
            cycle(0, b(9), 4);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("ar", int'(ar), x.ar);
                chk("pc", int'(pc), x.pc);
                chk("ac", int'(ac), x.ac);
                chk("ir", int'(ir), x.ir);
                chk("bus", int'(bus), x.bus);
                chk("e", int'(e_out), x.e);
                chk("co", int'(co), x.co);
                chk("ovf", int'(ovf), x.ovf);
                chk("z", int'(z), (x.ac == 0) ? 1 : 0);
                chk("n", int'(n), x.ac / 32768);
            end
        end
    end

    initial begin : stim
        logic [19:0] en;
        rst_n = 1'b0;
        bus_sel = '0;
        ctrl_en = '0;
        alu_op = 3'b111;
        for (int i = 0; i < 4096; i++) m_mem[i] = 0;
        model_reset();
        #12;
        chk("reset_ac", int'(ac), 0);
        chk("reset_pc", int'(pc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_ir", int'(ir), 0);
        chk("reset_e", int'(e_out), 0);

        // Zero-fill memory so every later read has a known value.
        cycle(0, b(2), 7);
        for (int i = 0; i < 4096; i++) cycle(0, b(16) | b(1), 7);

        // Fetch
        set_ac(16'h0123);
        cycle(0, b(2) | b(5), 7);
        cycle(3, b(16), 7);
        cycle(1, b(0), 7);
        cycle(6, b(12) | b(4), 7);
        cycle(4, b(0), 7);
        #1;
        chk("fetch_ir", int'(ir), 'h0123);
        chk("fetch_pc", int'(pc), 1);
        chk("fetch_ar", int'(ar), 'h123);

        // AND
        set_ac(16'h3C3C);
        cycle(3, b(16), 7);
        cycle(6, b(6), 7);
        set_ac(16'hF0F0);
        cycle(0, b(9), 1);
        #1;
        chk("and_ac", int'(ac), 'h3030);
        chk("and_z", int'(z), 0);
        chk("and_n", int'(n), 0);

        // ADD overflow and carry
        set_ac(16'h0001);
        cycle(3, b(6), 7);
        set_ac(16'h7FFF);
        cycle(0, b(9), 0);
        #1;
        chk("addv_ac", int'(ac), 'h8000);
        chk("addv_ovf", int'(ovf), 1);
        chk("addv_co", int'(co), 0);
        chk("addv_n", int'(n), 1);
        set_ac(16'hFFFF);
        cycle(0, b(9), 0);
        #1;
        chk("addc_ac", int'(ac), 0);
        chk("addc_co", int'(co), 1);
        chk("addc_e", int'(e_out), 1);
        chk("addc_z", int'(z), 1);

        // Rotates
        set_ac(16'h8001);
        cycle(0, b(19), 7);
        cycle(0, b(18), 7);
        cycle(0, b(9), 4);
        #1;
        chk("cil_ac", int'(ac), 'h0003);
        chk("cil_e", int'(e_out), 1);
        cycle(0, b(9), 5);
        #1;
        chk("cir_ac", int'(ac), 'h8001);
        chk("cir_e", int'(e_out), 1);

        // Priority and wrap
        cycle(0, b(9) | b(10) | b(11), 2);
        #1;
        chk("acprio_ac", int'(ac), 0);
        set_ac(16'h0FFF);
        cycle(3, b(3), 7);
        cycle(0, b(4), 7);
        #1;
        chk("pcwrap_pc", int'(pc), 0);
        cycle(0, b(18) | b(19), 7);
        #1;
        chk("eprio_e", int'(e_out), 0);

        // Asynchronous reset between edges
        set_ac(16'h1234);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ac", int'(ac), 0);
        chk("arst_pc", int'(pc), 0);
        chk("arst_ar", int'(ar), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus_sel = 3'b110;
        ctrl_en = '0;
        #1;
        chk("arst_mem0", int'(bus), 'h0123);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            en = '0;
            for (int k = 0; k < 20; k++)
                en[k] = ($urandom_range(3) == 0);
            cycle($urandom_range(7), en, $urandom_range(7));
        end

        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
